// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body tracker: direction codes,
// FSM state encoding and default playfield size.
package snake_pkg;

    localparam int unsigned DEF_GRID_W = 32;
    localparam int unsigned DEF_GRID_H = 24;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_MOVE = 2'd1,
        ST_SCAN = 2'd2,
        ST_DEAD = 2'd3
    } state_e;

    // Opposite directions differ only in the upper code bit.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head position for one step in a direction, with wall detection done
// before the add/subtract so coordinates never wrap.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W = DEF_GRID_W,
    parameter int unsigned GRID_H = DEF_GRID_H,
    parameter int unsigned XW     = 5,
    parameter int unsigned YW     = 5
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [1:0]    dir_i,
    output logic [XW-1:0] next_x_o,
    output logic [YW-1:0] next_y_o,
    output logic          wall_hit_o
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    always_comb begin
        next_x_o   = x_i;
        next_y_o   = y_i;
        wall_hit_o = 1'b0;
        case (dir_i)
            DIR_UP: begin
                if (y_i == '0) wall_hit_o = 1'b1;
                else           next_y_o   = y_i - YW'(1);
            end
            DIR_RIGHT: begin
                if (x_i == X_MAX) wall_hit_o = 1'b1;
                else              next_x_o   = x_i + XW'(1);
            end
            DIR_DOWN: begin
                if (y_i == Y_MAX) wall_hit_o = 1'b1;
                else              next_y_o   = y_i + YW'(1);
            end
            default: begin
                if (x_i == '0) wall_hit_o = 1'b1;
                else           next_x_o   = x_i - XW'(1);
            end
        endcase
    end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake head/body position tracker: moves one cell per tick, grows on apples,
// detects wall and self collision, and streams the body after every move.
module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned GRID_W   = DEF_GRID_W,
    parameter int unsigned GRID_H   = DEF_GRID_H,
    parameter int unsigned XW       = 5,
    parameter int unsigned YW       = 5,
    localparam int unsigned IW      = $clog2(MAX_LEN),
    localparam int unsigned LW      = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          move_tick,
    input  logic [1:0]    dir_in,
    input  logic          apple_eaten,
    output logic [XW-1:0] headX,
    output logic [YW-1:0] headY,
    output logic [XW-1:0] bodyX,
    output logic [YW-1:0] bodyY,
    output logic          body_valid,
    output logic [IW-1:0] body_idx,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          game_over
);

    state_e        state_q, state_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic [1:0]    pend_dir_q, pend_dir_d;
    logic [1:0]    mv_dir_q, mv_dir_d;
    logic          grow_q, grow_d;
    logic [XW-1:0] nxt_x_q, nxt_x_d;
    logic [YW-1:0] nxt_y_q, nxt_y_d;

    logic [XW-1:0] nh_x;
    logic [YW-1:0] nh_y;
    logic          nh_wall;
    logic          scan_hit;
    logic          scan_last;
    logic          busy_c;
    logic          body_valid_c;
    logic          game_over_c;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_next_head (
        .x_i        (seg_x_q[0]),
        .y_i        (seg_y_q[0]),
        .dir_i      (pend_dir_q),
        .next_x_o   (nh_x),
        .next_y_o   (nh_y),
        .wall_hit_o (nh_wall)
    );

    assign scan_hit  = (seg_x_q[idx_q] == seg_x_q[0]) && (seg_y_q[idx_q] == seg_y_q[0]);
    assign scan_last = (LW'(idx_q) == (len_q - LW'(1)));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: begin
                if (move_tick) state_d = nh_wall ? ST_DEAD : ST_MOVE;
            end
            ST_MOVE: state_d = ST_SCAN;
            ST_SCAN: begin
                if (scan_hit)       state_d = ST_DEAD;
                else if (scan_last) state_d = ST_WAIT;
            end
            default: state_d = ST_DEAD;
        endcase
    end

    always_comb begin
        busy_c       = 1'b0;
        body_valid_c = 1'b0;
        game_over_c  = 1'b0;
        case (state_q)
            ST_MOVE: busy_c = 1'b1;
            ST_SCAN: begin
                busy_c       = 1'b1;
                body_valid_c = 1'b1;
            end
            ST_DEAD: game_over_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: direction latch, move capture, shift commit, scan index.
    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cur_dir_d  = cur_dir_q;
        pend_dir_d = pend_dir_q;
        mv_dir_d   = mv_dir_q;
        nxt_x_d    = nxt_x_q;
        nxt_y_d    = nxt_y_q;
        grow_d     = grow_q | apple_eaten;

        if ((state_q != ST_DEAD) && (dir_in != opposite_dir(cur_dir_q))) begin
            pend_dir_d = dir_in;
        end

        case (state_q)
            ST_WAIT: begin
                if (move_tick && !nh_wall) begin
                    nxt_x_d  = nh_x;
                    nxt_y_d  = nh_y;
                    mv_dir_d = pend_dir_q;
                end
            end
            ST_MOVE: begin
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nxt_x_q;
                seg_y_d[0] = nxt_y_q;
                // An apple arriving on the commit cycle still counts for this move.
                if ((grow_q || apple_eaten) && (len_q < LW'(MAX_LEN))) begin
                    len_d = len_q + LW'(1);
                end
                grow_d    = 1'b0;
                cur_dir_d = mv_dir_q;
                idx_d     = IW'(1);
            end
            ST_SCAN: begin
                if (!scan_hit && !scan_last) idx_d = idx_q + IW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? XW'(GRID_W / 2 - i) : '0;
                seg_y_q[i] <= (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
            end
            len_q      <= LW'(INIT_LEN);
            idx_q      <= '0;
            cur_dir_q  <= DIR_RIGHT;
            pend_dir_q <= DIR_RIGHT;
            mv_dir_q   <= DIR_RIGHT;
            grow_q     <= 1'b0;
            nxt_x_q    <= '0;
            nxt_y_q    <= '0;
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cur_dir_q  <= cur_dir_d;
            pend_dir_q <= pend_dir_d;
            mv_dir_q   <= mv_dir_d;
            grow_q     <= grow_d;
            nxt_x_q    <= nxt_x_d;
            nxt_y_q    <= nxt_y_d;
        end
    end

    assign headX      = seg_x_q[0];
    assign headY      = seg_y_q[0];
    assign bodyX      = seg_x_q[idx_q];
    assign bodyY      = seg_y_q[idx_q];
    assign body_idx   = idx_q;
    assign length     = len_q;
    assign busy       = busy_c;
    assign body_valid = body_valid_c;
    assign game_over  = game_over_c;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Randomized and directed bench for snake_body_tracker against a queue-based
// model of the snake (positions as a list, growth and collisions by rule).
module tb_snake_body_tracker;

    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;
    localparam int GW       = 32;
    localparam int GH       = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_tick;
    logic [1:0] dir_in;
    logic       apple_eaten;
    logic [4:0] headX, headY, bodyX, bodyY;
    logic       body_valid;
    logic [3:0] body_idx;
    logic [4:0] length;
    logic       busy, game_over;

    logic [4:0] nh_x_i, nh_y_i, nh_x, nh_y;
    logic [1:0] nh_dir;
    logic       nh_wall;

    int n_checks, n_errors;

    // Reference snake: index 0 is the head, all MAX_LEN slots kept.
    int mx[$];
    int my[$];
    int m_len, m_cur, m_pend;
    bit m_grow, m_dead;

    always #5 clk = ~clk;

    snake_body_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .move_tick   (move_tick),
        .dir_in      (dir_in),
        .apple_eaten (apple_eaten),
        .headX       (headX),
        .headY       (headY),
        .bodyX       (bodyX),
        .bodyY       (bodyY),
        .body_valid  (body_valid),
        .body_idx    (body_idx),
        .length      (length),
        .busy        (busy),
        .game_over   (game_over)
    );

    snake_next_head u_nh (
        .x_i        (nh_x_i),
        .y_i        (nh_y_i),
        .dir_i      (nh_dir),
        .next_x_o   (nh_x),
        .next_y_o   (nh_y),
        .wall_hit_o (nh_wall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int opp(input int d);
        return d ^ 2;
    endfunction

    task automatic m_reset();
        mx.delete();
        my.delete();
        for (int i = 0; i < MAX_LEN; i++) begin
            mx.push_back(i < INIT_LEN ? GW / 2 - i : 0);
            my.push_back(i < INIT_LEN ? GH / 2 : 0);
        end
        m_len  = INIT_LEN;
        m_cur  = 1;
        m_pend = 1;
        m_grow = 0;
        m_dead = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One clock edge outside reset, with the model's per-edge rules applied.
    task automatic step_m();
        step();
        if (apple_eaten) m_grow = 1;
        if (!m_dead && int'(dir_in) != opp(m_cur)) m_pend = int'(dir_in);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        move_tick   = 1'b0;
        apple_eaten = 1'b0;
        step();
        reset = 1'b0;
        m_reset();
        chk("rst_headX", 32'(headX), GW / 2);
        chk("rst_headY", 32'(headY), GH / 2);
        chk("rst_length", 32'(length), INIT_LEN);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(body_valid), 0);
        chk("rst_idx", 32'(body_idx), 0);
        chk("rst_game_over", 32'(game_over), 0);
    endtask

    // apple_when: 0 none, 1 before tick, 2 with tick, 3 on commit cycle, 4 during scan.
    task automatic do_move(input int d, input int apple_when, input bit extra_tick, input int rst_at);
        int  nx, ny, mv;
        bit  wall, hit;
        dir_in      = 2'(d);
        apple_eaten = (apple_when == 1);
        step_m();
        apple_eaten = 1'b0;
        step_m();

        mv   = m_pend;
        nx   = mx[0];
        ny   = my[0];
        wall = 0;
        case (mv)
            0:       if (ny == 0)      wall = 1; else ny = ny - 1;
            1:       if (nx == GW - 1) wall = 1; else nx = nx + 1;
            2:       if (ny == GH - 1) wall = 1; else ny = ny + 1;
            default: if (nx == 0)      wall = 1; else nx = nx - 1;
        endcase
        nh_x_i = 5'(mx[0]);
        nh_y_i = 5'(my[0]);
        nh_dir = 2'(mv);
        #1;
        chk("nh_wall", 32'(nh_wall), 32'(wall));
        if (!wall) begin
            chk("nh_x", 32'(nh_x), nx);
            chk("nh_y", 32'(nh_y), ny);
        end

        move_tick   = 1'b1;
        apple_eaten = (apple_when == 2);
        step_m();
        move_tick   = 1'b0;
        apple_eaten = (apple_when == 3);
        if (m_dead || wall) begin
            m_dead      = 1;
            apple_eaten = 1'b0;
            chk("dead_game_over", 32'(game_over), 1);
            chk("dead_busy", 32'(busy), 0);
            chk("dead_valid", 32'(body_valid), 0);
            chk("dead_headX", 32'(headX), mx[0]);
            chk("dead_headY", 32'(headY), my[0]);
            return;
        end

        chk("move_busy", 32'(busy), 1);
        chk("move_valid", 32'(body_valid), 0);
        chk("move_headX", 32'(headX), mx[0]);
        step_m();
        apple_eaten = 1'b0;
        mx.push_front(nx);
        my.push_front(ny);
        void'(mx.pop_back());
        void'(my.pop_back());
        if (m_grow && m_len < MAX_LEN) m_len++;
        m_grow = 0;
        m_cur  = mv;

        for (int i = 1; i < m_len; i++) begin
            chk("scan_headX", 32'(headX), mx[0]);
            chk("scan_headY", 32'(headY), my[0]);
            chk("scan_length", 32'(length), m_len);
            chk("scan_busy", 32'(busy), 1);
            chk("scan_valid", 32'(body_valid), 1);
            chk("scan_idx", 32'(body_idx), i);
            chk("scan_bodyX", 32'(bodyX), mx[i]);
            chk("scan_bodyY", 32'(bodyY), my[i]);
            if (i == rst_at) begin
                do_reset();
                return;
            end
            hit         = (mx[i] == mx[0]) && (my[i] == my[0]);
            apple_eaten = (apple_when == 4) && (i == 1);
            move_tick   = extra_tick && (i == 1);
            step_m();
            apple_eaten = 1'b0;
            move_tick   = 1'b0;
            if (hit) begin
                m_dead = 1;
                chk("hit_game_over", 32'(game_over), 1);
                chk("hit_busy", 32'(busy), 0);
                chk("hit_valid", 32'(body_valid), 0);
                chk("hit_headX", 32'(headX), mx[0]);
                return;
            end
        end
        chk("end_busy", 32'(busy), 0);
        chk("end_valid", 32'(body_valid), 0);
        chk("end_game_over", 32'(game_over), 0);
        step_m();
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        move_tick   = 1'b0;
        apple_eaten = 1'b0;
        dir_in      = 2'd1;
        nh_x_i      = '0;
        nh_y_i      = '0;
        nh_dir      = '0;
        n_checks    = 0;
        n_errors    = 0;
        m_reset();
        @(negedge clk);

        // Basic move, reversal, turn, growth.
        do_reset();
        do_move(1, 0, 0, 0);
        chk("tp_first_headX", 32'(headX), 17);
        chk("tp_first_headY", 32'(headY), 12);
        do_move(3, 0, 0, 0);
        chk("tp_reverse_headX", 32'(headX), 18);
        do_move(0, 0, 1, 0);
        chk("tp_up_headY", 32'(headY), 11);
        do_move(0, 1, 0, 0);
        chk("tp_grow_length", 32'(length), 4);

        // Wall at the right edge, then ignored ticks while dead.
        do_reset();
        for (int k = 0; k < 15; k++) do_move(1, 0, 0, 0);
        for (int k = 0; k < 7; k++) do_move(0, 0, 0, 0);
        chk("tp_corner_headX", 32'(headX), 31);
        chk("tp_corner_headY", 32'(headY), 5);
        do_move(1, 0, 0, 0);
        chk("tp_wall_game_over", 32'(game_over), 1);
        do_move(2, 0, 0, 0);
        chk("tp_wall_headX", 32'(headX), 31);

        // Growth saturating at MAX_LEN.
        do_reset();
        for (int k = 0; k < 15; k++) do_move(1, (k % 4) + 1, k[0], 0);
        for (int k = 0; k < 4; k++) do_move(2, 2, 0, 0);
        chk("tp_max_length", 32'(length), MAX_LEN);

        // Self collision after growing to five segments.
        do_reset();
        do_move(1, 1, 0, 0);
        do_move(1, 1, 0, 0);
        chk("tp_len5", 32'(length), 5);
        do_move(2, 0, 0, 0);
        do_move(3, 0, 0, 0);
        do_move(0, 0, 0, 0);
        chk("tp_self_game_over", 32'(game_over), 1);

        // Reset during scan, then a clean move from the restored body.
        do_reset();
        do_move(1, 0, 0, 2);
        do_move(1, 0, 0, 0);
        chk("tp_after_abort_headX", 32'(headX), 17);

        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int n = 0; n < 40 && !m_dead; n++) begin
                do_move($urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                        $urandom_range(0, 7) == 0,
                        ($urandom_range(0, 29) == 0) ? $urandom_range(1, 3) : 0);
            end
            if (m_dead) do_move(0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/snake_body_tracker.md
Name: snake_body_tracker

Overview:
Holds the snake's head and body segment positions and advances them one cell per move tick in the latched direction. Grows when the downstream apple stage reports an apple eaten. Detects wall and self-collision. After each move it serially streams every body segment position to the apple generator, so that stage can reject apple locations that overlap the body.

Parameters:
MAX_LEN, 16, maximum segment count including head (2..64)
INIT_LEN, 3, segment count after reset (2..MAX_LEN)
GRID_W, 32, playfield columns
GRID_H, 24, playfield rows
XW, 5, x coordinate width, >= clog2(GRID_W)
YW, 5, y coordinate width, >= clog2(GRID_H)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
move_tick  input  1  single-cycle pulse; request to advance one cell
dir_in  input  2  requested direction: 0 up, 1 right, 2 down, 3 left
apple_eaten  input  1  pulse from apple generator (its is_Eaten)
headX  output  XW  current head column
headY  output  YW  current head row
bodyX  output  XW  streamed segment column, valid when body_valid=1
bodyY  output  YW  streamed segment row, valid when body_valid=1
body_valid  output  1  bodyX/bodyY carry a segment this cycle
body_idx  output  clog2(MAX_LEN)  index of the streamed segment
length  output  clog2(MAX_LEN)+1  current segment count
busy  output  1  high while a move/scan is in progress
game_over  output  1  sticky collision flag

Behaviour:
- Reset values:
  - headX=GRID_W/2, headY=GRID_H/2.
  - Segment i = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN.
  - All other segments = 0.
  - Latched dir = right (1). length=INIT_LEN. grow_pending=0.
  - Outputs busy=0, body_valid=0, body_idx=0, game_over=0. State = WAIT.
- Direction latch (every cycle, in any state except DEAD):
  - pend_dir <= dir_in unless dir_in is the opposite of the current dir; reversals are ignored.
  - cur_dir <= pend_dir only at the move commit.
- grow_pending:
  - Set by apple_eaten in any state.
  - Cleared at a move commit.
  - apple_eaten coincident with a committing move_tick applies to that move.
- FSM states: WAIT, MOVE, SCAN, DEAD.
- WAIT:
  - busy=0.
  - move_tick=1 -> compute next head from head + pend_dir.
  - If the next head leaves the grid (x=0 moving left, x=GRID_W-1 moving right, y=0 moving up, y=GRID_H-1 moving down): go to DEAD, positions unchanged.
  - Otherwise go to MOVE.
- MOVE (1 cycle, busy=1), commit:
  - seg[i] <= seg[i-1] for i=1..MAX_LEN-1; seg[0] <= next head.
  - If grow_pending and length<MAX_LEN, length <= length+1. Growth at MAX_LEN is silently dropped.
  - Go to SCAN with idx=1.
- SCAN (busy=1):
  - Each cycle body_valid=1, body_idx=idx, (bodyX,bodyY)=seg[idx].
  - If seg[idx]==head: go to DEAD.
  - Else if idx==length-1: go to WAIT.
  - Else idx++.
  - Scan takes length-1 cycles.
- Latency: move_tick at cycle T -> head visible at T+2; busy falls at T+2+(length-1).
- move_tick while busy=1 or in DEAD is ignored, not queued.
- DEAD: game_over=1, busy=0, body_valid=0, all positions frozen. Only reset exits DEAD.
- Reset asserted mid-MOVE or mid-SCAN aborts immediately to reset values. No partial shift survives.
- All coordinate arithmetic is unsigned. Wall detection happens before the add/subtract, so no wrap-around is ever produced.

Decomposition:
- Shared package snake_pkg holds:
  - Direction encodings DIR_UP/RIGHT/DOWN/LEFT.
  - An opposite-direction function.
  - Default GRID_W/GRID_H.
  - The FSM state enum (WAIT, MOVE, SCAN, DEAD).
- One combinational sub-module, snake_next_head:
  - Inputs: head x/y and dir.
  - Outputs: next x/y and wall_hit.
  - Reused by the testbench reference model.

Test Plan:
- Reset, default params -> head (16,12), segs (15,12),(14,12), length=3, busy=0, game_over=0.
- One move_tick, dir_in=1 -> head (17,12) at T+2, body_valid for 2 cycles streaming (16,12),(15,12), busy low at T+4.
- Head moving right, dir_in=3 held, then move_tick -> reversal ignored, head (17,12). Then dir_in=0, move_tick -> head (17,11).
- Pulse apple_eaten, then move_tick -> length=4, tail segment retains old tail position. Repeat at length=MAX_LEN -> length stays 16.
- Head at (31,5) moving right, move_tick -> game_over=1 next cycle, headX stays 31, further move_ticks ignored until reset.
- Grow to length 5, then turn down, left, up on consecutive moves -> head meets seg during SCAN, game_over=1. Assert reset mid-SCAN on a separate run -> all reset values the following cycle.
